// File: rtl/tiny_riscv_mem_arbiter.sv
`timescale 1ns/1ps
// Purpose : shares one single-beat memory port between instruction fetch and load/store.
//           Data has priority. A burst counter lets fetch win after MAX_DATA_BURST data grants.
// Latency : 3 cycles minimum. The request is sampled in IDLE, o_Mem_Valid rises the next cycle,
//           and the ack follows one cycle after i_Mem_Ready. Each wait state adds one cycle.
// Backpressure: requests are levels held until their ack. i_Mem_Ready stalls the access.
//           While a stall lasts, o_Mem_* hold steady.
//
// Ports:
//   i_Clk, i_Rst                     clock; synchronous active-high reset
//   i_Ifetch_Req/Addr                fetch request (level) and word address
//   o_Ifetch_Ack/Rdata               one-cycle completion pulse and fetched word
//   i_Data_Req/We/Addr/Wdata/Wmask   load/store request (level) and its payload
//   o_Data_Ack/Rdata                 one-cycle completion pulse and load data
//   o_Mem_Valid/Addr/We/Wdata/Wmask  registered memory request (mask forced to 0 on reads)
//   i_Mem_Ready/Rdata                memory handshake and read data
//   o_Busy                           high whenever the arbiter is not in IDLE
module tiny_riscv_mem_arbiter #(
   parameter int MAX_DATA_BURST = 4,
   parameter int ADDR_W         = 32
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Ifetch_Req,
   input  logic [ADDR_W-1:0] i_Ifetch_Addr,
   output logic              o_Ifetch_Ack,
   output logic [31:0]       o_Ifetch_Rdata,
   input  logic              i_Data_Req,
   input  logic              i_Data_We,
   input  logic [ADDR_W-1:0] i_Data_Addr,
   input  logic [31:0]       i_Data_Wdata,
   input  logic [3:0]        i_Data_Wmask,
   output logic              o_Data_Ack,
   output logic [31:0]       o_Data_Rdata,
   output logic              o_Mem_Valid,
   output logic [ADDR_W-1:0] o_Mem_Addr,
   output logic              o_Mem_We,
   output logic [31:0]       o_Mem_Wdata,
   output logic [3:0]        o_Mem_Wmask,
   input  logic              i_Mem_Ready,
   input  logic [31:0]       i_Mem_Rdata,
   output logic              o_Busy
);

   localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_MEM_IFETCH = 2'd1,
      S_MEM_DATA   = 2'd2,
      S_RESP       = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   // Remembers the owner of the current transaction, so RESP knows which ack to raise.
   logic                r_grant_fetch;
   logic [CNT_W-1:0]    r_burst;

   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_we;
   logic [31:0]         r_mem_wdata;
   logic [3:0]          r_mem_wmask;
   logic [31:0]         r_ifetch_rdata;
   logic [31:0]         r_data_rdata;

   logic                w_any_req;
   logic                w_burst_full;
   logic                w_fetch_wins;
   logic                w_in_mem;
   logic                w_mem_done;

   assign w_any_req    = i_Ifetch_Req | i_Data_Req;
   assign w_burst_full = (r_burst == BURST_MAX);
   // Data normally wins. Fetch wins when it is alone, or when data has used its whole burst.
   assign w_fetch_wins = i_Ifetch_Req & (~i_Data_Req | w_burst_full);
   assign w_in_mem     = (r_state == S_MEM_IFETCH) | (r_state == S_MEM_DATA);
   assign w_mem_done   = w_in_mem & i_Mem_Ready;

   assign o_Mem_Addr     = r_mem_addr;
   assign o_Mem_We       = r_mem_we;
   assign o_Mem_Wdata    = r_mem_wdata;
   assign o_Mem_Wmask    = r_mem_wmask;
   assign o_Ifetch_Rdata = r_ifetch_rdata;
   assign o_Data_Rdata   = r_data_rdata;

   // State register
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next_state = r_state;
      o_Mem_Valid  = 1'b0;
      o_Busy       = 1'b1;
      o_Ifetch_Ack = 1'b0;
      o_Data_Ack   = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_Busy = 1'b0;
            if (w_any_req) begin
               w_next_state = w_fetch_wins ? S_MEM_IFETCH : S_MEM_DATA;
            end
         end
         S_MEM_IFETCH, S_MEM_DATA: begin
            o_Mem_Valid = 1'b1;
            if (i_Mem_Ready) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            o_Ifetch_Ack = r_grant_fetch;
            o_Data_Ack   = ~r_grant_fetch;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Burst counter, request capture and read-data capture
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_grant_fetch  <= 1'b0;
         r_burst        <= '0;
         r_mem_addr     <= '0;
         r_mem_we       <= 1'b0;
         r_mem_wdata    <= '0;
         r_mem_wmask    <= 4'b0000;
         r_ifetch_rdata <= '0;
         r_data_rdata   <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            // The counter measures fetch starvation only, so it resets whenever fetch is not waiting.
            if (!i_Ifetch_Req || w_fetch_wins) begin
               r_burst <= '0;
            end else if (!w_burst_full) begin
               r_burst <= r_burst + CNT_W'(1);
            end

            // The loser's inputs are not sampled. It is re-arbitrated at the next IDLE cycle.
            if (w_any_req) begin
               r_grant_fetch <= w_fetch_wins;
               if (w_fetch_wins) begin
                  r_mem_addr  <= i_Ifetch_Addr;
                  r_mem_we    <= 1'b0;
                  r_mem_wdata <= '0;
                  r_mem_wmask <= 4'b0000;
               end else begin
                  r_mem_addr  <= i_Data_Addr;
                  r_mem_we    <= i_Data_We;
                  r_mem_wdata <= i_Data_Wdata;
                  r_mem_wmask <= i_Data_We ? i_Data_Wmask : 4'b0000;
               end
            end
         end

         // Stores complete without touching the load-data register.
         if (w_mem_done) begin
            if (r_state == S_MEM_IFETCH) begin
               r_ifetch_rdata <= i_Mem_Rdata;
            end else if (!r_mem_we) begin
               r_data_rdata <= i_Mem_Rdata;
            end
         end
      end
   end

endmodule
